// File: rtl/act_buf_scheduler.sv
// Activation buffer scheduler: write/read slot arbitration,
// byte-granular head/tail pointers and occupancy tracking.
module act_buf_scheduler #(
  parameter int dataSize          = 8,
  parameter int depth             = 1024,
  parameter int addrWidth         = 32,
  parameter int extInterfaceWidth = 32,
  parameter int intInterfaceWidth = 256
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 clear_i,
  input  logic                 ext_wr_req_i,
  output logic                 ext_wr_gnt_o,
  input  logic                 int_wr_req_i,
  output logic                 int_wr_gnt_o,
  input  logic                 ext_rd_req_i,
  output logic                 ext_rd_gnt_o,
  output logic                 ext_rd_valid_o,
  input  logic                 int_rd_req_i,
  output logic                 int_rd_gnt_o,
  output logic                 int_rd_valid_o,
  output logic                 buf_ext_wr_en_o,
  output logic                 buf_int_wr_en_o,
  output logic [addrWidth-1:0] buf_wr_addr_o,
  output logic                 buf_rd_en_o,
  output logic [addrWidth-1:0] buf_rd_addr_o,
  output logic [addrWidth-1:0] count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int EB = extInterfaceWidth / dataSize;
  localparam int IB = intInterfaceWidth / dataSize;
  localparam logic [addrWidth-1:0] DEP = addrWidth'(depth);
  localparam logic [addrWidth-1:0] EBA = addrWidth'(EB);
  localparam logic [addrWidth-1:0] IBA = addrWidth'(IB);

  logic [addrWidth-1:0] head_q, head_d;
  logic [addrWidth-1:0] tail_q, tail_d;
  logic [addrWidth-1:0] cnt_q, cnt_d;
  logic                 wr_prio_q, wr_prio_d;
  logic                 rd_prio_q, rd_prio_d;
  logic                 ext_vld_q, ext_vld_d;
  logic                 int_vld_q, int_vld_d;

  logic [addrWidth-1:0] space;
  logic ext_wr_ok, int_wr_ok, ext_rd_ok, int_rd_ok;
  logic ext_wr_g, int_wr_g, ext_rd_g, int_rd_g;
  logic [addrWidth-1:0] wbytes, rbytes;

  function automatic logic [addrWidth-1:0] wrap(
    input logic [addrWidth-1:0] a
  );
    return (a >= DEP) ? a - DEP : a;
  endfunction

  // Eligibility from registered state only (no bypass)
  always_comb begin
    space     = DEP - cnt_q;
    ext_wr_ok = ext_wr_req_i && (space >= EBA);
    int_wr_ok = int_wr_req_i && (space >= IBA)
                && ((head_q % IBA) == '0);
    ext_rd_ok = ext_rd_req_i && (cnt_q >= EBA);
    int_rd_ok = int_rd_req_i && (cnt_q >= IBA)
                && ((tail_q % IBA) == '0);
  end

  // Round-robin arbiters; priority only rotates on contention
  always_comb begin
    ext_wr_g  = 1'b0;
    int_wr_g  = 1'b0;
    ext_rd_g  = 1'b0;
    int_rd_g  = 1'b0;
    wr_prio_d = wr_prio_q;
    rd_prio_d = rd_prio_q;
    if (nrst && !clear_i) begin
      if (ext_wr_ok && int_wr_ok) begin
        ext_wr_g  = !wr_prio_q;
        int_wr_g  = wr_prio_q;
        wr_prio_d = !wr_prio_q;
      end else begin
        ext_wr_g = ext_wr_ok;
        int_wr_g = int_wr_ok;
      end
      if (ext_rd_ok && int_rd_ok) begin
        ext_rd_g  = !rd_prio_q;
        int_rd_g  = rd_prio_q;
        rd_prio_d = !rd_prio_q;
      end else begin
        ext_rd_g = ext_rd_ok;
        int_rd_g = int_rd_ok;
      end
    end
  end

  // Pointer, occupancy and read-valid next state
  always_comb begin
    wbytes = ext_wr_g ? EBA : (int_wr_g ? IBA : '0);
    rbytes = ext_rd_g ? EBA : (int_rd_g ? IBA : '0);
    head_d    = wrap(head_q + wbytes);
    tail_d    = wrap(tail_q + rbytes);
    cnt_d     = cnt_q + wbytes - rbytes;
    ext_vld_d = ext_rd_g;
    int_vld_d = int_rd_g;
    if (clear_i) begin
      head_d    = '0;
      tail_d    = '0;
      cnt_d     = '0;
      ext_vld_d = 1'b0;
      int_vld_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      wr_prio_q <= 1'b0;
      rd_prio_q <= 1'b0;
      ext_vld_q <= 1'b0;
      int_vld_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      wr_prio_q <= wr_prio_d;
      rd_prio_q <= rd_prio_d;
      ext_vld_q <= ext_vld_d;
      int_vld_q <= int_vld_d;
    end
  end

  assign ext_wr_gnt_o    = ext_wr_g;
  assign int_wr_gnt_o    = int_wr_g;
  assign ext_rd_gnt_o    = ext_rd_g;
  assign int_rd_gnt_o    = int_rd_g;
  assign buf_ext_wr_en_o = ext_wr_g;
  assign buf_int_wr_en_o = int_wr_g;
  assign buf_rd_en_o     = ext_rd_g | int_rd_g;
  assign buf_wr_addr_o   = head_q;
  assign buf_rd_addr_o   = tail_q;
  assign count_o         = cnt_q;
  assign ext_rd_valid_o  = ext_vld_q;
  assign int_rd_valid_o  = int_vld_q;
  assign full_o          = cnt_q > (DEP - EBA);
  assign empty_o         = cnt_q == '0;

  a_cnt_max : assert property (
    @(posedge clk) disable iff (!nrst) cnt_q <= DEP);
  a_cnt_min : assert property (
    @(posedge clk) disable iff (!nrst) rbytes <= cnt_q);
  a_one_wr : assert property (
    @(posedge clk) disable iff (!nrst) !(ext_wr_g && int_wr_g));
  a_one_rd : assert property (
    @(posedge clk) disable iff (!nrst) !(ext_rd_g && int_rd_g));

endmodule

// File: tb/tb_act_buf_scheduler.sv
// Directed testbench for act_buf_scheduler.
// One task per scenario, inline checks.
module tb_act_buf_scheduler;

  logic        clk = 1'b0;
  logic        nrst;
  logic        clear_i;
  logic        ext_wr_req, int_wr_req, ext_rd_req, int_rd_req;
  logic        ext_wr_gnt, int_wr_gnt, ext_rd_gnt, int_rd_gnt;
  logic        ext_rd_valid, int_rd_valid;
  logic        ext_wr_en, int_wr_en, rd_en;
  logic [31:0] wr_addr, rd_addr, count;
  logic        full, empty;

  int total = 0;
  int bad   = 0;

  act_buf_scheduler dut (
    .clk             (clk),
    .nrst            (nrst),
    .clear_i         (clear_i),
    .ext_wr_req_i    (ext_wr_req),
    .ext_wr_gnt_o    (ext_wr_gnt),
    .int_wr_req_i    (int_wr_req),
    .int_wr_gnt_o    (int_wr_gnt),
    .ext_rd_req_i    (ext_rd_req),
    .ext_rd_gnt_o    (ext_rd_gnt),
    .ext_rd_valid_o  (ext_rd_valid),
    .int_rd_req_i    (int_rd_req),
    .int_rd_gnt_o    (int_rd_gnt),
    .int_rd_valid_o  (int_rd_valid),
    .buf_ext_wr_en_o (ext_wr_en),
    .buf_int_wr_en_o (int_wr_en),
    .buf_wr_addr_o   (wr_addr),
    .buf_rd_en_o     (rd_en),
    .buf_rd_addr_o   (rd_addr),
    .count_o         (count),
    .full_o          (full),
    .empty_o         (empty)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ext_wr_req = 0; int_wr_req = 0;
    ext_rd_req = 0; int_rd_req = 0;
    clear_i = 0;
    nrst = 0;
    step();
    nrst = 1;
  endtask

  task automatic test_reset();
    nrst = 0; clear_i = 0;
    ext_wr_req = 1; int_wr_req = 1;
    ext_rd_req = 1; int_rd_req = 1;
    #2;
    total++; if ({ext_wr_gnt, int_wr_gnt, ext_rd_gnt, int_rd_gnt} !== 4'b0) begin
      bad++; $display("FAIL rst_gnt got=%b exp=0000", {ext_wr_gnt, int_wr_gnt, ext_rd_gnt, int_rd_gnt}); end
    total++; if ({ext_wr_en, int_wr_en, rd_en} !== 3'b0) begin
      bad++; $display("FAIL rst_en got=%b exp=000", {ext_wr_en, int_wr_en, rd_en}); end
    total++; if (wr_addr !== 0 || rd_addr !== 0 || count !== 0) begin
      bad++; $display("FAIL rst_ptr got=%0d/%0d/%0d exp=0/0/0", wr_addr, rd_addr, count); end
    total++; if ({empty, full, ext_rd_valid, int_rd_valid} !== 4'b1000) begin
      bad++; $display("FAIL rst_flags got=%b exp=1000", {empty, full, ext_rd_valid, int_rd_valid}); end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ext_wr_req = 1; #1;
      total++; if (ext_wr_gnt !== 1 || ext_wr_en !== 1 || wr_addr !== 32'(i * 4)) begin
        bad++; $display("FAIL basic_wr%0d got=%b/%0d exp=1/%0d", i, ext_wr_gnt, wr_addr, i * 4); end
      step();
    end
    ext_wr_req = 0;
    total++; if (wr_addr !== 16 || count !== 16) begin
      bad++; $display("FAIL basic_h16 got=%0d/%0d exp=16/16", wr_addr, count); end
    int_rd_req = 1; #1;
    total++; if (int_rd_gnt !== 0) begin
      bad++; $display("FAIL basic_rd_blk got=%b exp=0", int_rd_gnt); end
    step();
    int_rd_req = 0;
    total++; if (int_rd_valid !== 0) begin
      bad++; $display("FAIL basic_rd_blk_vld got=%b exp=0", int_rd_valid); end
    for (int i = 0; i < 4; i++) begin
      ext_wr_req = 1; #1;
      total++; if (ext_wr_gnt !== 1 || wr_addr !== 32'(16 + i * 4)) begin
        bad++; $display("FAIL basic_wr2_%0d got=%b/%0d exp=1/%0d", i, ext_wr_gnt, wr_addr, 16 + i * 4); end
      step();
    end
    ext_wr_req = 0;
    int_rd_req = 1; #1;
    total++; if (int_rd_gnt !== 1 || rd_en !== 1 || rd_addr !== 0) begin
      bad++; $display("FAIL basic_rd got=%b/%b/%0d exp=1/1/0", int_rd_gnt, rd_en, rd_addr); end
    step();
    int_rd_req = 0;
    total++; if (rd_addr !== 32 || count !== 0 || empty !== 1) begin
      bad++; $display("FAIL basic_after_rd got=%0d/%0d/%b exp=32/0/1", rd_addr, count, empty); end
    total++; if (int_rd_valid !== 1 || ext_rd_valid !== 0) begin
      bad++; $display("FAIL basic_vld got=%b%b exp=10", int_rd_valid, ext_rd_valid); end
    step();
    total++; if (int_rd_valid !== 0) begin
      bad++; $display("FAIL basic_vld_drop got=%b exp=0", int_rd_valid); end
  endtask

  task automatic test_alternation();
    do_reset();
    ext_wr_req = 1; int_wr_req = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++; if (ext_wr_gnt !== (i != 8) || int_wr_gnt !== (i == 8)) begin
        bad++; $display("FAIL alt_%0d got=%b%b exp=%b%b", i, ext_wr_gnt, int_wr_gnt, i != 8, i == 8); end
      total++; if (ext_wr_en && int_wr_en) begin
        bad++; $display("FAIL alt_dbl_%0d got=11 exp=not11", i); end
      step();
    end
    ext_wr_req = 0; int_wr_req = 0;
    total++; if (wr_addr !== 68 || count !== 68) begin
      bad++; $display("FAIL alt_end got=%0d/%0d exp=68/68", wr_addr, count); end
  endtask

  task automatic test_full();
    do_reset();
    int_wr_req = 1;
    for (int i = 0; i < 32; i++) begin
      #1;
      total++; if (int_wr_gnt !== 1 || wr_addr !== 32'(i * 32)) begin
        bad++; $display("FAIL full_fill%0d got=%b/%0d exp=1/%0d", i, int_wr_gnt, wr_addr, i * 32); end
      step();
    end
    total++; if (count !== 1024 || full !== 1 || wr_addr !== 0) begin
      bad++; $display("FAIL full_state got=%0d/%b/%0d exp=1024/1/0", count, full, wr_addr); end
    ext_wr_req = 1; #1;
    total++; if (ext_wr_gnt !== 0 || int_wr_gnt !== 0) begin
      bad++; $display("FAIL full_wr_blk got=%b%b exp=00", ext_wr_gnt, int_wr_gnt); end
    ext_rd_req = 1; #1;
    total++; if (ext_rd_gnt !== 1 || ext_wr_gnt !== 0) begin
      bad++; $display("FAIL full_rd got=%b%b exp=10", ext_rd_gnt, ext_wr_gnt); end
    step();
    ext_rd_req = 0;
    total++; if (count !== 1020 || full !== 0 || ext_rd_valid !== 1) begin
      bad++; $display("FAIL full_1020 got=%0d/%b/%b exp=1020/0/1", count, full, ext_rd_valid); end
    #1;
    total++; if (ext_wr_gnt !== 1 || int_wr_gnt !== 0) begin
      bad++; $display("FAIL full_regrant got=%b%b exp=10", ext_wr_gnt, int_wr_gnt); end
    step();
    ext_wr_req = 0; int_wr_req = 0;
    total++; if (count !== 1024 || full !== 1) begin
      bad++; $display("FAIL full_refill got=%0d/%b exp=1024/1", count, full); end
  endtask

  task automatic test_wrap();
    do_reset();
    ext_wr_req = 1; ext_rd_req = 1;
    #1;
    total++; if (ext_wr_gnt !== 1 || ext_rd_gnt !== 0) begin
      bad++; $display("FAIL wrap_first got=%b%b exp=10", ext_wr_gnt, ext_rd_gnt); end
    for (int i = 0; i < 255; i++) step();
    ext_wr_req = 0;
    total++; if (wr_addr !== 1020 || rd_addr !== 1016 || count !== 4) begin
      bad++; $display("FAIL wrap_pre got=%0d/%0d/%0d exp=1020/1016/4", wr_addr, rd_addr, count); end
    step();
    ext_rd_req = 0;
    total++; if (rd_addr !== 1020 || count !== 0) begin
      bad++; $display("FAIL wrap_setup got=%0d/%0d exp=1020/0", rd_addr, count); end
    ext_wr_req = 1; #1;
    total++; if (ext_wr_gnt !== 1 || wr_addr !== 1020) begin
      bad++; $display("FAIL wrap_wr got=%b/%0d exp=1/1020", ext_wr_gnt, wr_addr); end
    step();
    ext_wr_req = 0;
    total++; if (wr_addr !== 0 || count !== 4) begin
      bad++; $display("FAIL wrap_head got=%0d/%0d exp=0/4", wr_addr, count); end
    ext_rd_req = 1; #1;
    total++; if (ext_rd_gnt !== 1 || rd_addr !== 1020) begin
      bad++; $display("FAIL wrap_rd got=%b/%0d exp=1/1020", ext_rd_gnt, rd_addr); end
    step();
    ext_rd_req = 0;
    total++; if (rd_addr !== 0 || count !== 0 || empty !== 1) begin
      bad++; $display("FAIL wrap_tail got=%0d/%0d/%b exp=0/0/1", rd_addr, count, empty); end
  endtask

  task automatic test_simul();
    do_reset();
    ext_wr_req = 1;
    step(); step();
    ext_rd_req = 1; #1;
    total++; if (ext_wr_gnt !== 1 || ext_rd_gnt !== 1) begin
      bad++; $display("FAIL simul8_gnt got=%b%b exp=11", ext_wr_gnt, ext_rd_gnt); end
    step();
    ext_wr_req = 0; ext_rd_req = 0;
    total++; if (count !== 8 || wr_addr !== 12 || rd_addr !== 4) begin
      bad++; $display("FAIL simul8_state got=%0d/%0d/%0d exp=8/12/4", count, wr_addr, rd_addr); end
    do_reset();
    ext_wr_req = 1; ext_rd_req = 1; #1;
    total++; if (ext_wr_gnt !== 1 || ext_rd_gnt !== 0) begin
      bad++; $display("FAIL simul0_gnt got=%b%b exp=10", ext_wr_gnt, ext_rd_gnt); end
    step();
    ext_wr_req = 0; ext_rd_req = 0;
    total++; if (count !== 4 || ext_rd_valid !== 0) begin
      bad++; $display("FAIL simul0_state got=%0d/%b exp=4/0", count, ext_rd_valid); end
  endtask

  task automatic test_clear();
    do_reset();
    ext_wr_req = 1; int_wr_req = 1;
    step(); step();
    ext_rd_req = 1; clear_i = 1; #1;
    total++; if ({ext_wr_gnt, int_wr_gnt, ext_rd_gnt, rd_en} !== 4'b0) begin
      bad++; $display("FAIL clr_gnt got=%b exp=0000", {ext_wr_gnt, int_wr_gnt, ext_rd_gnt, rd_en}); end
    step();
    clear_i = 0; ext_rd_req = 0;
    total++; if (wr_addr !== 0 || rd_addr !== 0 || count !== 0 || ext_rd_valid !== 0) begin
      bad++; $display("FAIL clr_state got=%0d/%0d/%0d/%b exp=0/0/0/0", wr_addr, rd_addr, count, ext_rd_valid); end
    #1;
    total++; if (int_wr_gnt !== 1 || ext_wr_gnt !== 0) begin
      bad++; $display("FAIL clr_prio got=%b%b exp=01", ext_wr_gnt, int_wr_gnt); end
    step();
    ext_wr_req = 0; int_wr_req = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    ext_wr_req = 1;
    step();
    ext_wr_req = 0; ext_rd_req = 1; #1;
    total++; if (ext_rd_gnt !== 1) begin
      bad++; $display("FAIL arst_gnt got=%b exp=1", ext_rd_gnt); end
    #1 nrst = 0;
    #1;
    total++; if (ext_rd_gnt !== 0 || count !== 0) begin
      bad++; $display("FAIL arst_kill got=%b/%0d exp=0/0", ext_rd_gnt, count); end
    @(posedge clk); #1;
    total++; if (ext_rd_valid !== 0) begin
      bad++; $display("FAIL arst_vld1 got=%b exp=0", ext_rd_valid); end
    nrst = 1; ext_rd_req = 0;
    step();
    total++; if (ext_rd_valid !== 0) begin
      bad++; $display("FAIL arst_vld2 got=%b exp=0", ext_rd_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alternation();
    test_full();
    test_wrap();
    test_simul();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
